// File: rtl/alrdwr_bram_ctrl.sv
// Controller that puts a simple valid/ready read/write request interface in front of a single-port BRAM.
// Reads are credit-limited so that every read in flight already has a slot in the response FIFO.
module alrdwr_bram_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_BITS   = 2,
    parameter int DATA_WIDTH  = 8 << DATA_BITS,
    parameter int BRAM_STAGES = 1,
    parameter int ID_WIDTH    = 1,
    parameter int ARB_MODE    = 0,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // write request
    input  logic [ADDR_WIDTH-1:DATA_BITS]   s_al_waddr,
    input  logic                            s_al_wvalid,
    input  logic [DATA_WIDTH-1:0]           s_al_wdata,
    input  logic [DATA_WIDTH/8-1:0]         s_al_wstrb,
    output logic                            s_al_wready,
    // read request
    input  logic [ADDR_WIDTH-1:DATA_BITS]   s_al_araddr,
    input  logic                            s_al_arvalid,
    input  logic [ID_WIDTH-1:0]             s_al_arid,
    output logic                            s_al_arready,
    // read response
    output logic [DATA_WIDTH-1:0]           s_al_rdata,
    output logic                            s_al_rvalid,
    output logic [ID_WIDTH-1:0]             s_al_rid,
    input  logic                            s_al_rready,
    // BRAM port
    output logic [ADDR_WIDTH-1:DATA_BITS]   bram_addr,
    output logic                            bram_en,
    output logic [DATA_WIDTH/8-1:0]         bram_we,
    output logic [DATA_WIDTH-1:0]           bram_data_wr,
    input  logic [DATA_WIDTH-1:0]           bram_data_rd
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RESP_DEPTH);

    logic [CW-1:0]         credit_q, credit_d;
    logic                  rr_write_q, rr_write_d;
    logic                  pipe_vld_q [BRAM_STAGES];
    logic [ID_WIDTH-1:0]   pipe_id_q  [BRAM_STAGES];
    logic [DATA_WIDTH-1:0] fifo_data_q [RESP_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_q   [RESP_DEPTH];
    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic read_ok, read_elig, write_elig, write_wins, contended;
    logic rd_acc, wr_acc, push, pop;

    // Arbitration: write_wins says who takes a contended cycle.
    always_comb begin
        write_wins = 1'b0;
        case (ARB_MODE)
            1:       write_wins = 1'b1;
            2:       write_wins = rr_write_q;
            default: write_wins = 1'b0;
        endcase
    end

    assign read_ok      = rst_n && (credit_q < CREDIT_MAX);
    assign read_elig    = s_al_arvalid && read_ok;
    assign write_elig   = rst_n && s_al_wvalid;
    assign contended    = read_elig && write_elig;
    assign s_al_arready = read_ok && !(write_elig && write_wins);
    assign s_al_wready  = rst_n && !(read_elig && !write_wins);
    assign rd_acc       = s_al_arvalid && s_al_arready;
    assign wr_acc       = s_al_wvalid && s_al_wready;

    assign bram_en      = rd_acc || (wr_acc && (|s_al_wstrb));
    assign bram_addr    = wr_acc ? s_al_waddr : s_al_araddr;
    assign bram_data_wr = s_al_wdata;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_we
            assign bram_we[gi] = wr_acc && s_al_wstrb[gi];
        end
    endgenerate

    assign push        = pipe_vld_q[BRAM_STAGES-1];
    assign s_al_rvalid = rst_n && (wr_ptr_q != rd_ptr_q);
    assign pop         = s_al_rvalid && s_al_rready;
    assign s_al_rdata  = fifo_data_q[rd_ptr_q[PW-1:0]];
    assign s_al_rid    = fifo_id_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        credit_d   = credit_q;
        rr_write_d = rr_write_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (rd_acc && !pop) begin
            credit_d = credit_q + CW'(1);
        end else if (pop && !rd_acc) begin
            credit_d = credit_q - CW'(1);
        end
        // Round-robin memory only moves on contended cycles.
        if (contended) begin
            rr_write_d = rd_acc;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q   <= '0;
            rr_write_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            credit_q   <= credit_d;
            rr_write_q <= rr_write_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Read tag pipeline tracks the BRAM latency and advances every cycle.
    always_ff @(posedge clk) begin
        pipe_id_q[0] <= s_al_arid;
        for (int i = 1; i < BRAM_STAGES; i++) begin
            pipe_id_q[i] <= pipe_id_q[i-1];
        end
        if (!rst_n) begin
            for (int i = 0; i < BRAM_STAGES; i++) begin
                pipe_vld_q[i] <= 1'b0;
            end
        end else begin
            pipe_vld_q[0] <= rd_acc;
            for (int i = 1; i < BRAM_STAGES; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[PW-1:0]] <= bram_data_rd;
            fifo_id_q[wr_ptr_q[PW-1:0]]   <= pipe_id_q[BRAM_STAGES-1];
        end
    end

endmodule

// File: tb/tb_alrdwr_bram_ctrl.sv
// Directed bench for alrdwr_bram_ctrl: a round-robin instance on a BRAM model with 2-cycle read latency,
// plus a read-priority instance sharing the same request stimulus for arbitration comparisons.
module tb_alrdwr_bram_ctrl;

    localparam int AW = 12, DB = 2, DW = 32, NB = 4, STG = 2, IDW = 1, DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [AW-1:DB] s_al_waddr, s_al_araddr, bram_addr, rp_bram_addr;
    logic s_al_wvalid, s_al_wready, s_al_arvalid, s_al_arready, s_al_rvalid, s_al_rready;
    logic [DW-1:0] s_al_wdata, s_al_rdata, bram_data_wr, bram_data_rd;
    logic [NB-1:0] s_al_wstrb, bram_we, rp_bram_we;
    logic [IDW-1:0] s_al_arid, s_al_rid, rp_rid;
    logic bram_en, rp_wready, rp_arready, rp_rvalid, rp_bram_en;
    logic [DW-1:0] rp_rdata, rp_bram_data_wr, zero_rd;
    assign zero_rd = '0;

    int errors = 0;
    int checks = 0;

    alrdwr_bram_ctrl #(.ADDR_WIDTH(AW), .DATA_BITS(DB), .DATA_WIDTH(DW), .BRAM_STAGES(STG),
                       .ID_WIDTH(IDW), .ARB_MODE(2), .RESP_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_al_waddr(s_al_waddr), .s_al_wvalid(s_al_wvalid), .s_al_wdata(s_al_wdata),
        .s_al_wstrb(s_al_wstrb), .s_al_wready(s_al_wready),
        .s_al_araddr(s_al_araddr), .s_al_arvalid(s_al_arvalid), .s_al_arid(s_al_arid),
        .s_al_arready(s_al_arready),
        .s_al_rdata(s_al_rdata), .s_al_rvalid(s_al_rvalid), .s_al_rid(s_al_rid),
        .s_al_rready(s_al_rready),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_data_wr(bram_data_wr), .bram_data_rd(bram_data_rd)
    );

    alrdwr_bram_ctrl #(.ADDR_WIDTH(AW), .DATA_BITS(DB), .DATA_WIDTH(DW), .BRAM_STAGES(STG),
                       .ID_WIDTH(IDW), .ARB_MODE(0), .RESP_DEPTH(DEPTH)) u_dut_rp (
        .clk(clk), .rst_n(rst_n),
        .s_al_waddr(s_al_waddr), .s_al_wvalid(s_al_wvalid), .s_al_wdata(s_al_wdata),
        .s_al_wstrb(s_al_wstrb), .s_al_wready(rp_wready),
        .s_al_araddr(s_al_araddr), .s_al_arvalid(s_al_arvalid), .s_al_arid(s_al_arid),
        .s_al_arready(rp_arready),
        .s_al_rdata(rp_rdata), .s_al_rvalid(rp_rvalid), .s_al_rid(rp_rid),
        .s_al_rready(s_al_rready),
        .bram_addr(rp_bram_addr), .bram_en(rp_bram_en), .bram_we(rp_bram_we),
        .bram_data_wr(rp_bram_data_wr), .bram_data_rd(zero_rd)
    );

    // BRAM model: read-first, two register stages on the read path.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rd_s1;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (i == 5 || i == 6) ? 32'h1122_3344 : DW'(i);
            end
        end else if (bram_en) begin
            for (int b = 0; b < NB; b++) begin
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_data_wr[8*b +: 8];
            end
            rd_s1 <= mem[bram_addr];
        end
        bram_data_rd <= rd_s1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_read(input logic [AW-1:DB] a, input logic [IDW-1:0] id,
                           output logic [DW-1:0] d, output logic [IDW-1:0] rid_o, output logic ok);
        int n;
        @(negedge clk);
        s_al_araddr = a; s_al_arid = id; s_al_arvalid = 1'b1; s_al_rready = 1'b1;
        n = 0; #1;
        while (!s_al_arready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        s_al_arvalid = 1'b0;
        n = 0; #1;
        while (!s_al_rvalid && n < 20) begin @(negedge clk); #1; n++; end
        ok = s_al_rvalid; d = s_al_rdata; rid_o = s_al_rid;
        @(negedge clk);
        $display("read addr=%h id=%0d -> data=%h rid=%0d ok=%0d", a, id, d, rid_o, ok);
    endtask

    task automatic test_reset();
        @(negedge clk);
        s_al_arvalid = 1'b1; s_al_wvalid = 1'b1; s_al_wstrb = 4'hF; #1;
        checks++; if (s_al_arready !== 1'b0) begin errors++; $display("FAIL reset_arready got=%b exp=0", s_al_arready); end
        checks++; if (s_al_wready !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b exp=0", s_al_wready); end
        checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL reset_bram_en got=%b exp=0", bram_en); end
        checks++; if (bram_we !== 4'h0) begin errors++; $display("FAIL reset_bram_we got=%h exp=0", bram_we); end
        checks++; if (s_al_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", s_al_rvalid); end
        @(negedge clk);
        rst_n = 1'b1; s_al_arvalid = 1'b0; s_al_wvalid = 1'b0; s_al_wstrb = 4'h0;
        $display("reset released");
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        s_al_araddr = 10'h10; s_al_arid = 1'b1; s_al_arvalid = 1'b1; s_al_rready = 1'b1; #1;
        checks++; if (s_al_arready !== 1'b1) begin errors++; $display("FAIL lat_arready got=%b exp=1", s_al_arready); end
        checks++; if (bram_en !== 1'b1) begin errors++; $display("FAIL lat_bram_en got=%b exp=1", bram_en); end
        checks++; if (bram_addr !== 10'h10) begin errors++; $display("FAIL lat_bram_addr got=%h exp=010", bram_addr); end
        checks++; if (bram_we !== 4'h0) begin errors++; $display("FAIL lat_bram_we got=%h exp=0", bram_we); end
        @(negedge clk);
        s_al_arvalid = 1'b0; s_al_arid = 1'b0; #1;
        checks++; if (s_al_rvalid !== 1'b0) begin errors++; $display("FAIL lat_rvalid_t1 got=%b exp=0", s_al_rvalid); end
        @(negedge clk); #1;
        checks++; if (s_al_rvalid !== 1'b0) begin errors++; $display("FAIL lat_rvalid_t2 got=%b exp=0", s_al_rvalid); end
        @(negedge clk); #1;
        checks++; if (s_al_rvalid !== 1'b1) begin errors++; $display("FAIL lat_rvalid_t3 got=%b exp=1", s_al_rvalid); end
        checks++; if (s_al_rdata !== 32'h10) begin errors++; $display("FAIL lat_rdata got=%h exp=00000010", s_al_rdata); end
        checks++; if (s_al_rid !== 1'b1) begin errors++; $display("FAIL lat_rid got=%b exp=1", s_al_rid); end
        $display("read addr=010 id=1 -> data=%h rid=%0d at T+3", s_al_rdata, s_al_rid);
        @(negedge clk); #1;
        checks++; if (s_al_rvalid !== 1'b0) begin errors++; $display("FAIL lat_rvalid_popped got=%b exp=0", s_al_rvalid); end
    endtask

    task automatic test_write_strobe();
        logic [DW-1:0] d;
        logic [IDW-1:0] rid;
        logic ok;
        @(negedge clk);
        s_al_waddr = 10'h5; s_al_wdata = 32'hAABB_CCDD; s_al_wstrb = 4'b0101; s_al_wvalid = 1'b1; #1;
        checks++; if (s_al_wready !== 1'b1) begin errors++; $display("FAIL wr_wready got=%b exp=1", s_al_wready); end
        checks++; if (bram_en !== 1'b1) begin errors++; $display("FAIL wr_bram_en got=%b exp=1", bram_en); end
        checks++; if (bram_we !== 4'b0101) begin errors++; $display("FAIL wr_bram_we got=%b exp=0101", bram_we); end
        checks++; if (bram_addr !== 10'h5) begin errors++; $display("FAIL wr_bram_addr got=%h exp=005", bram_addr); end
        checks++; if (bram_data_wr !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_bram_data got=%h exp=aabbccdd", bram_data_wr); end
        $display("write addr=005 data=aabbccdd strb=0101");
        @(negedge clk);
        s_al_waddr = 10'h6; s_al_wstrb = 4'b0100; #1;
        checks++; if (bram_we !== 4'b0100) begin errors++; $display("FAIL wr2_bram_we got=%b exp=0100", bram_we); end
        $display("write addr=006 data=aabbccdd strb=0100");
        @(negedge clk);
        s_al_waddr = 10'h7; s_al_wstrb = 4'b0000; #1;
        checks++; if (s_al_wready !== 1'b1) begin errors++; $display("FAIL wr0_wready got=%b exp=1", s_al_wready); end
        checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL wr0_bram_en got=%b exp=0", bram_en); end
        $display("write addr=007 strb=0000");
        @(negedge clk);
        s_al_wvalid = 1'b0;
        do_read(10'h5, 1'b0, d, rid, ok);
        checks++; if (ok !== 1'b1 || d !== 32'h11BB_33DD) begin errors++; $display("FAIL rd5 got=%h ok=%b exp=11bb33dd", d, ok); end
        do_read(10'h6, 1'b1, d, rid, ok);
        checks++; if (ok !== 1'b1 || d !== 32'h11BB_3344) begin errors++; $display("FAIL rd6 got=%h ok=%b exp=11bb3344", d, ok); end
        checks++; if (rid !== 1'b1) begin errors++; $display("FAIL rd6_rid got=%b exp=1", rid); end
        do_read(10'h7, 1'b0, d, rid, ok);
        checks++; if (ok !== 1'b1 || d !== 32'h7) begin errors++; $display("FAIL rd7 got=%h ok=%b exp=00000007", d, ok); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int n;
        s_al_rready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s_al_araddr = 10'h20 + 10'(acc); s_al_arvalid = 1'b1; #1;
            checks++; if (s_al_arready !== (k < 4)) begin errors++; $display("FAIL b2b_arready[%0d] got=%b exp=%0d", k, s_al_arready, (k < 4)); end
            $display("read request addr=%h arready=%b", s_al_araddr, s_al_arready);
            if (s_al_arready) acc++;
        end
        @(negedge clk); #1;
        checks++; if (s_al_arready !== 1'b0) begin errors++; $display("FAIL b2b_full_arready got=%b exp=0", s_al_arready); end
        @(negedge clk);
        s_al_rready = 1'b1; #1;
        checks++; if (s_al_rvalid !== 1'b1 || s_al_rdata !== 32'h20) begin errors++; $display("FAIL b2b_first got=%h v=%b exp=00000020", s_al_rdata, s_al_rvalid); end
        @(negedge clk);
        s_al_rready = 1'b0; #1;
        checks++; if (s_al_arready !== 1'b1) begin errors++; $display("FAIL b2b_credit_back got=%b exp=1", s_al_arready); end
        @(negedge clk);
        s_al_arvalid = 1'b0; #1;
        checks++; if (s_al_arready !== 1'b0) begin errors++; $display("FAIL b2b_refull got=%b exp=0", s_al_arready); end
        s_al_rready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!s_al_rvalid && n < 20) begin @(negedge clk); #1; n++; end
            checks++; if (s_al_rvalid !== 1'b1 || s_al_rdata !== 32'h21 + 32'(j)) begin errors++; $display("FAIL b2b_order[%0d] got=%h v=%b exp=%h", j, s_al_rdata, s_al_rvalid, 32'h21 + 32'(j)); end
            $display("response data=%h", s_al_rdata);
            @(negedge clk); #1;
        end
    endtask

    task automatic test_arbitration();
        s_al_rready = 1'b1; s_al_waddr = 10'h100; s_al_wdata = 32'h0; s_al_wstrb = 4'hF; s_al_araddr = 10'h30;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_al_arvalid = 1'b1; s_al_wvalid = 1'b1; #1;
            checks++; if (s_al_arready !== (k % 2 == 0) || s_al_wready !== (k % 2 == 1)) begin errors++; $display("FAIL arb_rr[%0d] got ar=%b w=%b exp ar=%0d", k, s_al_arready, s_al_wready, (k % 2 == 0)); end
            checks++; if (rp_arready !== 1'b1 || rp_wready !== 1'b0) begin errors++; $display("FAIL arb_rp[%0d] got ar=%b w=%b exp ar=1 w=0", k, rp_arready, rp_wready); end
            $display("contended cycle %0d grant=%s", k, s_al_arready ? "read" : "write");
        end
        @(negedge clk);
        s_al_arvalid = 1'b0; #1;
        checks++; if (s_al_wready !== 1'b1) begin errors++; $display("FAIL arb_lone_write got=%b exp=1", s_al_wready); end
        @(negedge clk);
        s_al_arvalid = 1'b1; #1;
        checks++; if (s_al_arready !== 1'b1 || s_al_wready !== 1'b0) begin errors++; $display("FAIL arb_rr_hold got ar=%b w=%b exp ar=1 w=0", s_al_arready, s_al_wready); end
        @(negedge clk);
        s_al_arvalid = 1'b0; s_al_wvalid = 1'b0; s_al_wstrb = 4'h0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_credit_full_write();
        s_al_rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_al_araddr = 10'h40 + 10'(k); s_al_arvalid = 1'b1; #1;
            checks++; if (s_al_arready !== 1'b1 || rp_arready !== 1'b1) begin errors++; $display("FAIL fill[%0d] got=%b/%b exp=1/1", k, s_al_arready, rp_arready); end
        end
        @(negedge clk);
        s_al_wvalid = 1'b1; s_al_waddr = 10'h101; s_al_wdata = 32'hDEAD_BEEF; s_al_wstrb = 4'hF; #1;
        checks++; if (s_al_arready !== 1'b0 || s_al_wready !== 1'b1) begin errors++; $display("FAIL full_rr got ar=%b w=%b exp ar=0 w=1", s_al_arready, s_al_wready); end
        checks++; if (rp_arready !== 1'b0 || rp_wready !== 1'b1) begin errors++; $display("FAIL full_rp got ar=%b w=%b exp ar=0 w=1", rp_arready, rp_wready); end
        checks++; if (bram_en !== 1'b1 || bram_addr !== 10'h101 || bram_we !== 4'hF) begin errors++; $display("FAIL full_bram got en=%b a=%h we=%h exp 1/101/f", bram_en, bram_addr, bram_we); end
        $display("write addr=101 with credits exhausted");
        @(negedge clk);
        s_al_arvalid = 1'b0; s_al_wvalid = 1'b0; s_al_wstrb = 4'h0; s_al_rready = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        s_al_rready = 1'b0;
        @(negedge clk);
        s_al_araddr = 10'h50; s_al_arvalid = 1'b1;
        @(negedge clk);
        s_al_araddr = 10'h51;
        @(negedge clk);
        s_al_arvalid = 1'b0; rst_n = 1'b0; #1;
        checks++; if (s_al_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_during got=%b exp=0", s_al_rvalid); end
        @(negedge clk);
        rst_n = 1'b1; s_al_wvalid = 1'b1; s_al_waddr = 10'h102; s_al_wstrb = 4'h0; #1;
        checks++; if (s_al_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_after got=%b exp=0", s_al_rvalid); end
        checks++; if (s_al_wready !== 1'b1) begin errors++; $display("FAIL rst_first_accept got=%b exp=1", s_al_wready); end
        @(negedge clk);
        s_al_wvalid = 1'b0; s_al_rready = 1'b1;
        repeat (6) begin @(negedge clk); #1; if (s_al_rvalid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_stale got=%0d exp=0", seen); end
        s_al_rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_al_araddr = 10'h60 + 10'(k); s_al_arvalid = 1'b1; #1;
            checks++; if (s_al_arready !== (k < 4)) begin errors++; $display("FAIL rst_credit[%0d] got=%b exp=%0d", k, s_al_arready, (k < 4)); end
        end
        @(negedge clk);
        s_al_arvalid = 1'b0; s_al_rready = 1'b1;
        repeat (8) @(negedge clk);
        $display("reset with reads in flight done, stale=%0d", seen);
    endtask

    initial begin
        rst_n = 1'b0;
        s_al_waddr = '0; s_al_wvalid = 1'b0; s_al_wdata = '0; s_al_wstrb = '0;
        s_al_araddr = '0; s_al_arvalid = 1'b0; s_al_arid = '0; s_al_rready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_read_latency();
        test_write_strobe();
        test_back_to_back();
        test_arbitration();
        test_credit_full_write();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
